// File: rtl/cache_cfg_pkg.sv
// Cache-wide configuration shared by the controller and its sub-FSMs.
package cache_cfg_pkg;
  localparam int unsigned NUM_ENTRIES = 8;
endpackage

// File: rtl/ctrl_types_pkg.sv
// Sub-FSM state encodings and the status word each sub-FSM returns to the parent controller.
package ctrl_types_pkg;
  typedef enum logic [2:0] {
    DEL_ST_START  = 3'd0,
    DEL_ST_DELETE = 3'd1,
    DEL_ST_ERROR  = 3'd2,
    DEL_ST_WAIT   = 3'd3,
    DEL_ST_SCAN   = 3'd4,
    DEL_ST_DONE   = 3'd5
  } del_substate_e;

  typedef struct packed {
    logic done;
    logic error;
  } sub_cmd_t;
endpackage

// File: rtl/del_onehot_chk.sv
// Combinational exactly-one-hot detector; an all-zero or multi-bit vector is rejected.
module del_onehot_chk #(
  parameter int unsigned WIDTH = cache_cfg_pkg::NUM_ENTRIES
) (
  input  logic [WIDTH-1:0] vec,
  output logic             onehot_c
);
  always_comb onehot_c = (vec != '0) && ((vec & (vec - WIDTH'(1))) == '0);
endmodule

// File: rtl/del_ctrl_fsm.sv
// Delete sub-FSM: single-key delete with configurable lookup latency.
// Flush-all mode (sequential scan of the occupancy bitmap) is built only when DEL_FLUSH_EN is defined.
module del_ctrl_fsm
  import ctrl_types_pkg::*;
#(
  parameter int unsigned NUM_ENTRIES = cache_cfg_pkg::NUM_ENTRIES,
  parameter int unsigned LOOKUP_LAT  = 0
) (
  input  logic                               clk,
  input  logic                               rst_n,
  input  logic                               en,
  input  logic                               enter,
  input  logic                               mode,
  input  logic                               hit,
  input  logic [NUM_ENTRIES-1:0]             idx_in,
  input  logic [NUM_ENTRIES-1:0]             valid_in,
  output logic                               delete_out,
  output logic [NUM_ENTRIES-1:0]             idx_out,
  output logic                               busy,
  output logic [$clog2(NUM_ENTRIES+1)-1:0]   del_count,
  output sub_cmd_t                           cmd
);
  localparam int unsigned CNT_W     = $clog2(NUM_ENTRIES + 1);
  localparam int unsigned WAIT_W    = 3;
  localparam int unsigned WAIT_INIT = (LOOKUP_LAT > 0) ? LOOKUP_LAT - 1 : 0;

  del_substate_e          state_q, state_d;
  logic [NUM_ENTRIES-1:0] idx_q, idx_d;
  logic [WAIT_W-1:0]      wait_q, wait_d;
  logic [CNT_W-1:0]       count_d;
  logic                   del_d, busy_d;
  logic [NUM_ENTRIES-1:0] idx_out_d;
  sub_cmd_t               cmd_d;
  logic                   onehot_c, match_ok_c;

`ifdef DEL_FLUSH_EN
  localparam int unsigned PTR_W = $clog2(NUM_ENTRIES);
  logic [PTR_W-1:0] ptr_q, ptr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
`else
  logic unused_flush;
  assign unused_flush = ^{mode, valid_in};
`endif

  del_onehot_chk #(.WIDTH(NUM_ENTRIES)) u_onehot (
    .vec      (idx_in),
    .onehot_c (onehot_c)
  );

  assign match_ok_c = hit & onehot_c;

  // State, captured index and registered (Moore) outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= DEL_ST_START;
      idx_q      <= '0;
      wait_q     <= '0;
      del_count  <= '0;
      delete_out <= 1'b0;
      idx_out    <= '0;
      busy       <= 1'b0;
      cmd        <= '0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      wait_q     <= wait_d;
      del_count  <= count_d;
      delete_out <= del_d;
      idx_out    <= idx_out_d;
      busy       <= busy_d;
      cmd        <= cmd_d;
    end
  end

`ifdef DEL_FLUSH_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q <= '0;
      cnt_q <= '0;
    end else begin
      ptr_q <= ptr_d;
      cnt_q <= cnt_d;
    end
  end
`endif

  // Next state; outputs are decoded from the next state so they register alongside it
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    wait_d  = wait_q;
    count_d = del_count;
`ifdef DEL_FLUSH_EN
    ptr_d   = ptr_q;
    cnt_d   = cnt_q;
`endif
    if (enter) begin
      state_d = DEL_ST_START;
      wait_d  = '0;
`ifdef DEL_FLUSH_EN
      ptr_d   = '0;
      cnt_d   = '0;
`endif
    end else if (en) begin
      case (state_q)
        DEL_ST_START: begin
`ifdef DEL_FLUSH_EN
          if (mode) begin
            state_d = DEL_ST_SCAN;
            ptr_d   = '0;
            cnt_d   = '0;
          end else
`endif
          if (LOOKUP_LAT == 0) begin
            state_d = match_ok_c ? DEL_ST_DELETE : DEL_ST_ERROR;
            idx_d   = match_ok_c ? idx_in : idx_q;
          end else begin
            state_d = DEL_ST_WAIT;
            wait_d  = WAIT_W'(WAIT_INIT);
          end
        end
        DEL_ST_WAIT: begin
          if (wait_q == '0) begin
            state_d = match_ok_c ? DEL_ST_DELETE : DEL_ST_ERROR;
            idx_d   = match_ok_c ? idx_in : idx_q;
          end else begin
            wait_d = WAIT_W'(wait_q - WAIT_W'(1));
          end
        end
        DEL_ST_DELETE: begin
          count_d = CNT_W'(1);
          state_d = DEL_ST_START;
        end
        DEL_ST_ERROR: begin
          count_d = '0;
          state_d = DEL_ST_START;
        end
`ifdef DEL_FLUSH_EN
        DEL_ST_SCAN: begin
          // count the strobe actually presented for the current pointer
          cnt_d = CNT_W'(cnt_q + CNT_W'(delete_out));
          if (ptr_q == PTR_W'(NUM_ENTRIES - 1)) state_d = DEL_ST_DONE;
          else                                   ptr_d   = PTR_W'(ptr_q + PTR_W'(1));
        end
        DEL_ST_DONE: begin
          count_d = cnt_q;
          state_d = DEL_ST_START;
        end
`endif
        default: state_d = DEL_ST_START;
      endcase
    end

    del_d     = delete_out;
    idx_out_d = idx_out;
    busy_d    = busy;
    cmd_d     = cmd;
    if (enter || en) begin
      del_d     = 1'b0;
      idx_out_d = '0;
      busy_d    = (state_d != DEL_ST_START);
      cmd_d     = '0;
      case (state_d)
        DEL_ST_DELETE: begin
          del_d      = 1'b1;
          idx_out_d  = idx_d;
          cmd_d.done = 1'b1;
        end
        DEL_ST_ERROR: cmd_d.error = 1'b1;
`ifdef DEL_FLUSH_EN
        DEL_ST_SCAN: begin
          if (valid_in[ptr_d]) begin
            del_d     = 1'b1;
            idx_out_d = NUM_ENTRIES'(1) << ptr_d;
          end
        end
        DEL_ST_DONE: cmd_d.done = 1'b1;
`endif
        default: ;
      endcase
    end
  end
endmodule
